// File: rtl/pipe_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: state encodings and defaults.
package pipe_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MD_WAIT = 2'b01,
        HALT    = 2'b10,
        STEP    = 2'b11
    } seq_state_t;

    localparam int unsigned MD_LATENCY_DEFAULT = 4;
    localparam int unsigned CNT_W_DEFAULT      = 16;
    localparam int unsigned MD_CNT_W           = 4;

endpackage

// File: rtl/pipe_sequencer_if.sv
// Hazard inputs, pipeline-register controls and status between sequencer and datapath.
interface pipe_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_md;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic             halt_req;
    logic             step_pulse;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             md_busy;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  id_rs, id_rt, id_uses_rt, id_md, ex_rd, ex_mem_read, ex_redirect,
               halt_req, step_pulse,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
               id_ex_flush, md_busy, state, stall_cnt, flush_cnt
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, id_md, ex_rd, ex_mem_read, ex_redirect,
               halt_req, step_pulse,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
               id_ex_flush, md_busy, state, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: stage enables/flushes for load-use, redirect, mult/div and halt/step.
module pipe_sequencer
    import pipe_sequencer_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    pipe_sequencer_if.master  bus
);

    localparam logic [MD_CNT_W-1:0] MD_RELOAD = MD_CNT_W'(MD_LATENCY - 1);

    seq_state_t          state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic                resume_halt_q, resume_halt_d;
    logic                load_use;
    logic                pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic                if_id_flush, id_ex_flush, md_busy;
    logic                stall_inc, flush_inc;

    assign load_use = bus.ex_mem_read && (bus.ex_rd != '0) &&
                      ((bus.ex_rd == bus.id_rs) ||
                       (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            md_cnt_q      <= '0;
            resume_halt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            resume_halt_q <= resume_halt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;
        resume_halt_d = resume_halt_q;
        case (state_q)
            RUN, STEP: begin
                if (!bus.ex_redirect && !load_use && bus.id_md) begin
                    state_d       = MD_WAIT;
                    md_cnt_d      = MD_RELOAD;
                    // A mult/div issued by a single step returns to HALT, not RUN.
                    resume_halt_d = (state_q == STEP);
                end else if (state_q == STEP)
                    state_d = bus.halt_req ? HALT : RUN;
                else if (!bus.ex_redirect && !load_use && bus.halt_req)
                    state_d = HALT;
                else
                    state_d = RUN;
            end
            MD_WAIT: begin
                md_cnt_d = md_cnt_q - MD_CNT_W'(1);
                if (md_cnt_q <= MD_CNT_W'(1)) begin
                    state_d       = (resume_halt_q && bus.halt_req) ? HALT : RUN;
                    resume_halt_d = 1'b0;
                end
            end
            HALT: begin
                if (!bus.halt_req)
                    state_d = RUN;
                else if (bus.step_pulse)
                    state_d = STEP;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        md_busy     = 1'b0;
        flush_inc   = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN, STEP: begin
                    if (bus.ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                    md_busy  = 1'b1;
                end
                HALT: begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                end
                default: ;
            endcase
        end
        stall_inc = !reset && (state_q != HALT) && !pc_en;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clock),
        .clr   (reset),
        .inc   (stall_inc),
        .count (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clock),
        .clr   (reset),
        .inc   (flush_inc),
        .count (bus.flush_cnt)
    );

    assign bus.pc_en       = pc_en;
    assign bus.if_id_en    = if_id_en;
    assign bus.id_ex_en    = id_ex_en;
    assign bus.ex_mem_en   = ex_mem_en;
    assign bus.mem_wb_en   = mem_wb_en;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.md_busy     = md_busy;
    assign bus.state       = state_q;

endmodule
